// File: rtl/tim_sr_irq.sv
// Timer status register with per-flag over-capture, masked irq and per-flag DMA requests.
// Latency: flag visible 1 cycle after its set condition; irq and dma_req 1 cycle after the flag.
// No backpressure: events are never stalled, and a repeat event on a set flag raises over-capture.
module tim_sr_irq #(
    parameter int N_FLAGS   = 4,
    parameter int EDGE_DET  = 1,
    parameter int IRQ_PULSE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_FLAGS-1:0]     ev_in,
    input  logic                   sr_wr,
    input  logic [2*N_FLAGS-1:0]   sr_wdata,
    input  logic                   ier_wr,
    input  logic [2*N_FLAGS-1:0]   ier_wdata,
    output logic [2*N_FLAGS-1:0]   sr_rdata,
    output logic [2*N_FLAGS-1:0]   ier_rdata,
    input  logic [N_FLAGS-1:0]     dma_ack,
    output logic [N_FLAGS-1:0]     dma_req,
    output logic                   irq
);

    localparam int N = N_FLAGS;

    logic [N-1:0]   ev_q, ev_d;
    logic [N-1:0]   flag_q, flag_d;
    logic [N-1:0]   ovf_q, ovf_d;
    logic [N-1:0]   dma_req_q, dma_req_d;
    logic [2*N-1:0] ier_q, ier_d;
    logic           irq_q, irq_d;
    logic           pend_q, pend_d;

    logic [N-1:0]   set_v;
    logic [N-1:0]   clr_v;
    logic [N-1:0]   ovf_set;
    logic [N-1:0]   ovf_clr;
    logic [N-1:0]   ie;
    logic [N-1:0]   de;
    logic           pend;

    always_comb begin
        ev_d      = ev_in;
        ie        = ier_q[N-1:0];
        de        = ier_q[2*N-1:N];

        if (EDGE_DET != 0) begin
            set_v = ev_in & ~ev_q;
        end else begin
            set_v = ev_in;
        end

        // rc_w0: only written zeros clear; a DMA ack clears the event flag but not over-capture
        clr_v   = ({N{sr_wr}} & ~sr_wdata[N-1:0]) | dma_ack;
        ovf_clr = {N{sr_wr}} & ~sr_wdata[2*N-1:N];

        // An event arriving together with a clear is treated as consumed, not overrun
        ovf_set = set_v & flag_q & ~clr_v;

        flag_d  = set_v | (flag_q & ~clr_v);
        ovf_d   = ovf_set | (ovf_q & ~ovf_clr);
        ier_d   = ier_wr ? ier_wdata : ier_q;

        pend      = (|(flag_q & ie)) | (|(ovf_q & ie));
        pend_d    = pend;
        dma_req_d = flag_q & de;

        if (IRQ_PULSE != 0) begin
            irq_d = pend & ~pend_q;
        end else begin
            irq_d = pend;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q      <= '0;
            flag_q    <= '0;
            ovf_q     <= '0;
            ier_q     <= '0;
            dma_req_q <= '0;
            irq_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            ev_q      <= ev_d;
            flag_q    <= flag_d;
            ovf_q     <= ovf_d;
            ier_q     <= ier_d;
            dma_req_q <= dma_req_d;
            irq_q     <= irq_d;
            pend_q    <= pend_d;
        end
    end

    assign sr_rdata  = {ovf_q, flag_q};
    assign ier_rdata = ier_q;
    assign dma_req   = dma_req_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_tim_sr_irq.sv
// Directed bench for tim_sr_irq: default, pulse-irq and level-detect instances share stimulus.
module tb_tim_sr_irq;

    logic       clk;
    logic       rst_n;
    logic [3:0] ev_in;
    logic       sr_wr;
    logic [7:0] sr_wdata;
    logic       ier_wr;
    logic [7:0] ier_wdata;
    logic [3:0] dma_ack;

    logic [7:0] sr_d, ier_d, sr_p, ier_p, sr_l, ier_l;
    logic [3:0] dma_d, dma_p, dma_l;
    logic       irq_d, irq_p, irq_l;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tim_sr_irq #(.N_FLAGS(4), .EDGE_DET(1), .IRQ_PULSE(0)) dut (
        .clk(clk), .rst_n(rst_n), .ev_in(ev_in), .sr_wr(sr_wr), .sr_wdata(sr_wdata),
        .ier_wr(ier_wr), .ier_wdata(ier_wdata), .sr_rdata(sr_d), .ier_rdata(ier_d),
        .dma_ack(dma_ack), .dma_req(dma_d), .irq(irq_d)
    );

    tim_sr_irq #(.N_FLAGS(4), .EDGE_DET(1), .IRQ_PULSE(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .ev_in(ev_in), .sr_wr(sr_wr), .sr_wdata(sr_wdata),
        .ier_wr(ier_wr), .ier_wdata(ier_wdata), .sr_rdata(sr_p), .ier_rdata(ier_p),
        .dma_ack(dma_ack), .dma_req(dma_p), .irq(irq_p)
    );

    tim_sr_irq #(.N_FLAGS(4), .EDGE_DET(0), .IRQ_PULSE(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .ev_in(ev_in), .sr_wr(sr_wr), .sr_wdata(sr_wdata),
        .ier_wr(ier_wr), .ier_wdata(ier_wdata), .sr_rdata(sr_l), .ier_rdata(ier_l),
        .dma_ack(dma_ack), .dma_req(dma_l), .irq(irq_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ev_in     = 4'h0;
        sr_wr     = 1'b0;
        sr_wdata  = 8'h00;
        ier_wr    = 1'b0;
        ier_wdata = 8'h00;
        dma_ack   = 4'h0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic write_ier(input logic [7:0] v);
        ier_wr    = 1'b1;
        ier_wdata = v;
        step();
        ier_wr    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        ev_in     = 4'h0;
        sr_wr     = 1'b0;
        sr_wdata  = 8'h00;
        ier_wr    = 1'b0;
        ier_wdata = 8'h00;
        dma_ack   = 4'h0;
        for (int i = 0; i < 3; i++) begin
            ev_in = ~ev_in;
            step();
            n_checks++;
            if (sr_d !== 8'h00 || irq_d !== 1'b0 || dma_d !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: sr=%h irq=%b dma=%h, want 00/0/0", i, sr_d, irq_d, dma_d);
            end
            n_checks++;
            if (sr_l !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold_level cyc%0d: sr=%h, want 00", i, sr_l);
            end
        end
        ev_in = 4'h0;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (sr_d !== 8'h00 || ier_d !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release: sr=%h ier=%h, want 00/00", sr_d, ier_d);
        end
        ev_in = 4'h1;
        step();
        n_checks++;
        if (sr_d !== 8'h01) begin
            n_fail++;
            $display("FAIL first_edge: sr=%h, want 01", sr_d);
        end
    endtask

    task automatic test_set_clear();
        do_reset();
        write_ier(8'h01);
        n_checks++;
        if (ier_d !== 8'h01) begin
            n_fail++;
            $display("FAIL ier_load: ier=%h, want 01", ier_d);
        end
        ev_in = 4'h1;
        step();
        n_checks++;
        if (sr_d !== 8'h01 || irq_d !== 1'b0) begin
            n_fail++;
            $display("FAIL set_visible: sr=%h irq=%b, want 01/0", sr_d, irq_d);
        end
        ev_in = 4'h0;
        step();
        n_checks++;
        if (irq_d !== 1'b1 || dma_d !== 4'h0) begin
            n_fail++;
            $display("FAIL irq_assert: irq=%b dma=%h, want 1/0", irq_d, dma_d);
        end
        sr_wr    = 1'b1;
        sr_wdata = 8'hFE;
        step();
        sr_wr = 1'b0;
        n_checks++;
        if (sr_d !== 8'h00 || irq_d !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_w0: sr=%h irq=%b, want 00/1", sr_d, irq_d);
        end
        step();
        n_checks++;
        if (irq_d !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_deassert: irq=%b, want 0", irq_d);
        end
        ev_in = 4'h1;
        step();
        ev_in = 4'h0;
        sr_wr    = 1'b1;
        sr_wdata = 8'hFF;
        step();
        sr_wr = 1'b0;
        n_checks++;
        if (sr_d !== 8'h01) begin
            n_fail++;
            $display("FAIL write1_noop: sr=%h, want 01", sr_d);
        end
    endtask

    task automatic test_overcapture();
        do_reset();
        ev_in = 4'h4;
        step();
        ev_in = 4'h0;
        step();
        ev_in = 4'h4;
        step();
        ev_in = 4'h0;
        n_checks++;
        if (sr_d !== 8'h44) begin
            n_fail++;
            $display("FAIL ovf_set: sr=%h, want 44", sr_d);
        end
        sr_wr    = 1'b1;
        sr_wdata = 8'h00;
        step();
        sr_wr = 1'b0;
        n_checks++;
        if (sr_d !== 8'h00) begin
            n_fail++;
            $display("FAIL ovf_clear: sr=%h, want 00", sr_d);
        end
        ev_in = 4'h4;
        step();
        ev_in = 4'h0;
        step();
        ev_in    = 4'h4;
        sr_wr    = 1'b1;
        sr_wdata = 8'hFB;
        step();
        ev_in = 4'h0;
        sr_wr = 1'b0;
        n_checks++;
        if (sr_d !== 8'h04) begin
            n_fail++;
            $display("FAIL set_beats_clear: sr=%h, want 04", sr_d);
        end
    endtask

    task automatic test_dma_ack();
        do_reset();
        write_ier(8'h20);
        ev_in = 4'h2;
        step();
        ev_in = 4'h0;
        step();
        n_checks++;
        if (sr_d !== 8'h02 || dma_d !== 4'h2) begin
            n_fail++;
            $display("FAIL dma_req_assert: sr=%h dma=%h, want 02/2", sr_d, dma_d);
        end
        ev_in   = 4'h2;
        dma_ack = 4'h2;
        step();
        ev_in   = 4'h0;
        dma_ack = 4'h0;
        n_checks++;
        if (sr_d !== 8'h02 || dma_d !== 4'h2) begin
            n_fail++;
            $display("FAIL ack_vs_set: sr=%h dma=%h, want 02/2", sr_d, dma_d);
        end
        step();
        n_checks++;
        if (dma_d !== 4'h2 || irq_d !== 1'b0) begin
            n_fail++;
            $display("FAIL dma_hold: dma=%h irq=%b, want 2/0", dma_d, irq_d);
        end
        dma_ack = 4'h2;
        step();
        dma_ack = 4'h0;
        n_checks++;
        if (sr_d !== 8'h00) begin
            n_fail++;
            $display("FAIL ack_clear: sr=%h, want 00", sr_d);
        end
        step();
        n_checks++;
        if (dma_d !== 4'h0) begin
            n_fail++;
            $display("FAIL dma_drop: dma=%h, want 0", dma_d);
        end
    endtask

    task automatic test_irq_pulse();
        do_reset();
        write_ier(8'h03);
        ev_in = 4'h1;
        step();
        ev_in = 4'h0;
        step();
        n_checks++;
        if (irq_p !== 1'b1) begin
            n_fail++;
            $display("FAIL pulse1_hi: irq=%b, want 1", irq_p);
        end
        ev_in = 4'h2;
        step();
        ev_in = 4'h0;
        n_checks++;
        if (irq_p !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse1_lo: irq=%b, want 0", irq_p);
        end
        step();
        n_checks++;
        if (irq_p !== 1'b0 || sr_p !== 8'h03 || irq_d !== 1'b1) begin
            n_fail++;
            $display("FAIL pulse_no_retrig: irq_p=%b sr=%h irq_lvl=%b, want 0/03/1", irq_p, sr_p, irq_d);
        end
        sr_wr    = 1'b1;
        sr_wdata = 8'h00;
        step();
        sr_wr = 1'b0;
        step();
        ev_in = 4'h2;
        step();
        ev_in = 4'h0;
        n_checks++;
        if (irq_p !== 1'b0 || sr_p !== 8'h02) begin
            n_fail++;
            $display("FAIL pulse2_pre: irq=%b sr=%h, want 0/02", irq_p, sr_p);
        end
        step();
        n_checks++;
        if (irq_p !== 1'b1) begin
            n_fail++;
            $display("FAIL pulse2_hi: irq=%b, want 1", irq_p);
        end
        step();
        n_checks++;
        if (irq_p !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse2_lo: irq=%b, want 0", irq_p);
        end
        write_ier(8'h00);
        n_checks++;
        if (irq_d !== 1'b1) begin
            n_fail++;
            $display("FAIL ie_off_lag: irq=%b, want 1", irq_d);
        end
        step();
        n_checks++;
        if (irq_d !== 1'b0 || sr_d !== 8'h02) begin
            n_fail++;
            $display("FAIL ie_off: irq=%b sr=%h, want 0/02", irq_d, sr_d);
        end
    endtask

    task automatic test_level();
        do_reset();
        ev_in = 4'h8;
        step();
        n_checks++;
        if (sr_l !== 8'h08) begin
            n_fail++;
            $display("FAIL level_first: sr=%h, want 08", sr_l);
        end
        step();
        n_checks++;
        if (sr_l !== 8'h88) begin
            n_fail++;
            $display("FAIL level_ovf: sr=%h, want 88", sr_l);
        end
        step();
        sr_wr    = 1'b1;
        sr_wdata = 8'h00;
        step();
        sr_wr = 1'b0;
        n_checks++;
        if (sr_l !== 8'h08) begin
            n_fail++;
            $display("FAIL level_clear_hold: sr=%h, want 08", sr_l);
        end
        step();
        ev_in = 4'h0;
        n_checks++;
        if (sr_l !== 8'h88 || sr_d !== 8'h00) begin
            n_fail++;
            $display("FAIL level_end: sr_l=%h sr_edge=%h, want 88/00", sr_l, sr_d);
        end
        step();
        n_checks++;
        if (sr_l !== 8'h88) begin
            n_fail++;
            $display("FAIL level_release: sr=%h, want 88", sr_l);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        write_ier(8'hFF);
        ev_in = 4'hF;
        step();
        ev_in = 4'h0;
        step();
        n_checks++;
        if (sr_d !== 8'h0F || irq_d !== 1'b1 || dma_d !== 4'hF) begin
            n_fail++;
            $display("FAIL midop_pre: sr=%h irq=%b dma=%h, want 0F/1/F", sr_d, irq_d, dma_d);
        end
        dma_ack = 4'h1;
        rst_n   = 1'b0;
        #1;
        n_checks++;
        if (sr_d !== 8'h00 || irq_d !== 1'b0 || dma_d !== 4'h0 || ier_d !== 8'h00) begin
            n_fail++;
            $display("FAIL midop_async: sr=%h irq=%b dma=%h ier=%h, want 0", sr_d, irq_d, dma_d, ier_d);
        end
        step();
        dma_ack = 4'h0;
        rst_n   = 1'b1;
        step();
        n_checks++;
        if (sr_d !== 8'h00 || dma_d !== 4'h0) begin
            n_fail++;
            $display("FAIL midop_after: sr=%h dma=%h, want 00/0", sr_d, dma_d);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_set_clear();
        test_overcapture();
        test_dma_ack();
        test_irq_pulse();
        test_level();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
